pulse_req_arbiter: RTL and testbench

Multi-channel pulse collector for the capture control path. Single-cycle event pulses from up to 16 sources in one clock domain are captured into sticky pending flags. Pending channels are served round-robin through a four-phase req/ack handshake that carries a channel ID. The downstream side is normally a CDC handshake stage. Events that arrive while a channel is already pending are merged into that pending event and counted per channel.

---
 rtl/pulse_req_arb_pkg.sv | 17 +
 rtl/pulse_req_arbiter_rr_pick.sv | 31 +++
 rtl/pulse_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_pulse_req_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_req_arb_pkg.sv
// Shared types and constants for pulse_req_arbiter: FSM encoding, channel limit, ID width helper.
package pulse_req_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } arb_state_e;

  localparam int NUM_CH_MAX = 16;

  // Channel-ID width; a floor of one bit keeps req_id a real vector.
  function automatic int calc_id_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pulse_req_arbiter_rr_pick.sv
// Combinational round-robin search: first set pend bit at or above pointer, wrapping.
module rr_pick
  import pulse_req_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int ID_W  = calc_id_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pend,
  input  logic [ID_W-1:0]   pointer,
  output logic [ID_W-1:0]   winner,
  output logic              valid
);

  logic [ID_W-1:0] idx_s;
  logic            hit_s;

  // Scan upward from pointer; only the first hit updates the winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s  = ID_W'((int'(pointer) + k) % NUM_CH);
      hit_s  = pend[idx_s] & ~valid;
      winner = hit_s ? idx_s : winner;
      valid  = valid | pend[idx_s];
    end
  end

endmodule

// File: rtl/pulse_req_arbiter.sv
// Pulse collector with round-robin four-phase req/ack service.
// Optional per-channel merge counters under PULSE_REQ_ARB_OVF_CNT_EN.
module pulse_req_arbiter
  import pulse_req_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  localparam int ID_W  = calc_id_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pulse_in,
  input  logic [NUM_CH-1:0]       mask,
  output logic                    req,
  output logic [ID_W-1:0]         req_id,
  input  logic                    ack,
  output logic [NUM_CH-1:0]       pend,
  output logic                    busy,
  input  logic                    ovf_clr,
  output logic [NUM_CH*CNT_W-1:0] ovf_cnt
);

  arb_state_e        state_r;
  logic              req_r;
  logic [ID_W-1:0]   req_id_r;
  logic [ID_W-1:0]   ptr_r;
  logic [NUM_CH-1:0] pend_r;

  logic [ID_W-1:0]   winner_s;
  logic              pick_valid_s;
  logic              grant_s;
  logic [ID_W-1:0]   ptr_next_s;
  logic [NUM_CH-1:0] set_s;
  logic [NUM_CH-1:0] clr_s;
  logic [NUM_CH-1:0] merge_s;
  logic [NUM_CH-1:0] pend_next_s;

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .pend    (pend_r),
    .pointer (ptr_r),
    .winner  (winner_s),
    .valid   (pick_valid_s)
  );

  // Grant decision and pending-flag next state; a new capture beats a same-cycle grant clear.
  always_comb begin
    grant_s     = (state_r == ST_IDLE) & pick_valid_s & ~ack;
    ptr_next_s  = (winner_s == ID_W'(NUM_CH - 1)) ? '0 : winner_s + ID_W'(1);
    set_s       = pulse_in & mask;
    clr_s       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr_s[i] = grant_s & (winner_s == ID_W'(i));
    end
    merge_s     = set_s & pend_r & ~clr_s;
    pend_next_s = (pend_r & ~clr_s) | set_s;
  end

  // Handshake FSM with registered req, req_id, pointer and pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      req_r    <= 1'b0;
      req_id_r <= '0;
      ptr_r    <= '0;
      pend_r   <= '0;
    end else begin
      pend_r <= pend_next_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            req_r    <= 1'b1;
            req_id_r <= winner_s;
            ptr_r    <= ptr_next_s;
            state_r  <= ST_REQ;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (ack) begin
            req_r   <= 1'b0;
            state_r <= ST_WAIT_LOW;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_WAIT_LOW: begin
          if (!ack) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_LOW;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req    = req_r;
  assign req_id = req_id_r;
  assign pend   = pend_r;
  assign busy   = (state_r != ST_IDLE) | (|pend_r);

`ifdef PULSE_REQ_ARB_OVF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r [NUM_CH];

  // Saturating merge counters; a merge coinciding with a clear leaves a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ovf_clr) begin
          cnt_r[i] <= merge_s[i] ? CNT_W'(1) : '0;
        end else if (merge_s[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    ovf_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ovf_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
    end
  end
`else
  logic unused_cnt_s;

  assign ovf_cnt      = '0;
  assign unused_cnt_s = ovf_clr ^ (|merge_s);
`endif

endmodule

// File: tb/tb_pulse_req_arbiter.sv
// Self-checking bench for pulse_req_arbiter: vector table, directed corner cases, random run vs reference model.
module tb_pulse_req_arbiter;
  localparam int N     = 4;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef PULSE_REQ_ARB_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  pulse_in;
  logic [N-1:0]  mask;
  logic          req;
  logic [1:0]    req_id;
  logic          ack;
  logic [N-1:0]  pend;
  logic          busy;
  logic          ovf_clr;
  logic [N*CW-1:0] ovf_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit [N-1:0] m_pend;
  int         m_ptr;
  bit         m_req;
  int         m_id;
  int         m_hs;      // 0 = no transfer, 1 = request out, 2 = waiting for ack low
  int         m_cnt [N];

  typedef struct {
    logic [N-1:0] pulse;
    logic         ack;
    logic         exp_req;
    logic [1:0]   exp_id;
    logic [N-1:0] exp_pend;
    logic         exp_busy;
  } vec_t;

  vec_t tbl [6];

  pulse_req_arbiter #(.NUM_CH(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .mask(mask),
    .req(req), .req_id(req_id), .ack(ack), .pend(pend),
    .busy(busy), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_req = 1'b0; m_id = 0; m_hs = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_update();
    bit [N-1:0] s;
    bit         g;
    int         w;
    bit         mg;
    s = pulse_in & mask;
    g = 1'b0;
    w = 0;
    if (m_hs == 0 && m_pend != '0 && !ack) begin
      for (int k = N - 1; k >= 0; k--)
        if (m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      g = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      mg = s[i] && m_pend[i] && !(g && w == i);
      if (ovf_clr) m_cnt[i] = mg ? 1 : 0;
      else if (mg && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      if (!CNT_EN) m_cnt[i] = 0;
    end
    if (g) m_pend[w] = 1'b0;
    m_pend = m_pend | s;
    if (g) begin
      m_hs = 1; m_req = 1'b1; m_id = w; m_ptr = (w + 1) % N;
    end else if (m_hs == 1 && ack) begin
      m_hs = 2; m_req = 1'b0;
    end else if (m_hs == 2 && !ack) begin
      m_hs = 0;
    end
  endtask

  task automatic model_compare();
    logic [N*CW-1:0] ec;
    for (int i = 0; i < N; i++) ec[i*CW +: CW] = CW'(m_cnt[i]);
    chk("m_req", 32'(req), 32'(m_req));
    chk("m_req_id", 32'(req_id), 32'(m_id));
    chk("m_pend", 32'(pend), 32'(m_pend));
    chk("m_busy", 32'(busy), 32'((m_hs != 0) || (m_pend != '0)));
    chk("m_ovf_cnt", 32'(ovf_cnt), 32'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_req_id", 32'(req_id), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Wait for a request (bounded), check its ID, then complete the handshake.
  task automatic serve(input int id, input string nm);
    int n;
    n = 0;
    while (req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_req"}, 32'(req), 32'd1);
    chk({nm, "_id"}, 32'(req_id), 32'(id));
    ack = 1'b1; step();
    chk({nm, "_drop"}, 32'(req), 32'd0);
    ack = 1'b0; step();
  endtask

  initial begin
    int order_a [4];
    int order_b [4];
    order_a = '{0, 1, 2, 3};
    order_b = '{2, 3, 0, 1};
    tbl[0] = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1};
    tbl[1] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1};
    tbl[2] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1};
    tbl[3] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1};
    tbl[4] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};
    tbl[5] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0};

    pulse_in = '0; mask = 4'hF; ack = 1'b0; ovf_clr = 1'b0;
    model_reset();
    do_reset();

    // Single event on channel 2
    for (int v = 0; v < 6; v++) begin
      pulse_in = tbl[v].pulse;
      ack      = tbl[v].ack;
      step();
      chk($sformatf("tbl%0d_req", v), 32'(req), 32'(tbl[v].exp_req));
      chk($sformatf("tbl%0d_id", v), 32'(req_id), 32'(tbl[v].exp_id));
      chk($sformatf("tbl%0d_pend", v), 32'(pend), 32'(tbl[v].exp_pend));
      chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].exp_busy));
    end
    chk("single_ovf", 32'(ovf_cnt), 32'd0);

    // Round robin from pointer 0
    do_reset();
    pulse_in = 4'hF; step(); pulse_in = '0;
    for (int k = 0; k < 4; k++) serve(order_a[k], $sformatf("rr0_%0d", k));
    // Move pointer to 2 by serving channel 1 alone, then all four again
    pulse_in = 4'b0010; step(); pulse_in = '0;
    serve(1, "rr_setup");
    pulse_in = 4'hF; step(); pulse_in = '0;
    for (int k = 0; k < 4; k++) serve(order_b[k], $sformatf("rr2_%0d", k));

    // Merge and saturation on channel 1 with ack held low
    pulse_in = 4'b0010;
    for (int c = 0; c < 6; c++) step();
    pulse_in = '0;
    chk("sat_cnt1", 32'(ovf_cnt[3:2]), CNT_EN ? 32'd3 : 32'd0);
    chk("sat_req", 32'(req), 32'd1);
    chk("sat_id", 32'(req_id), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("clr_cnt1", 32'(ovf_cnt[3:2]), 32'd0);
    ack = 1'b1; step(); ack = 1'b0; step();
    serve(1, "sat_regrant");

    // Set/clear collision on channel 0
    pulse_in = 4'b0001; step();
    step();
    pulse_in = '0;
    chk("col_req", 32'(req), 32'd1);
    chk("col_id", 32'(req_id), 32'd0);
    chk("col_pend0", 32'(pend[0]), 32'd1);
    chk("col_cnt0", 32'(ovf_cnt[1:0]), 32'd0);
    ack = 1'b1; step(); ack = 1'b0; step();
    serve(0, "col_regrant");

    // Ack high while idle blocks the grant
    ack = 1'b1; pulse_in = 4'b1000; step(); pulse_in = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ackhi_noreq", 32'(req), 32'd0);
      chk("ackhi_pend3", 32'(pend[3]), 32'd1);
    end
    ack = 1'b0; step();
    chk("ackhi_req", 32'(req), 32'd1);
    chk("ackhi_id", 32'(req_id), 32'd3);
    // Reset in the middle of the handshake with another channel pending
    pulse_in = 4'b0010; step(); pulse_in = '0;
    do_reset();

    // Randomised run against the model
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) pulse_in[i] = ($urandom_range(0, 2) == 0);
      mask    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      ack     = 1'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      if (c == 400) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
